structure_tensor_gen: RTL and testbench

Producer of the six structure-tensor components consumed by the optical-flow velocity stage. It takes one spatio-temporal gradient sample (gx, gy, gt) per enabled clock and forms the six products. Each product is summed over a sliding horizontal window of WINDOW samples within an image line. It emits xx, yy, tt, xy, xt, yt at the tensor width the downstream flow calculation expects, plus a valid flag. It sits directly upstream of the flow-calculation block and shares its clk/en pipeline-advance convention.

---
 rtl/structure_tensor_gen.sv | 110 +++++++++++
 tb/tb_structure_tensor_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/structure_tensor_gen.sv
// Structure-tensor generator: per-sample gradient products (stage 1) summed over a
// sliding WINDOW-sample horizontal window that restarts at each line (stage 2).
module structure_tensor_gen #(
   parameter int GRAD_WIDTH   = 10,
   parameter int TENSOR_WIDTH = 24,
   parameter int WINDOW       = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic                           line_start,
   input  logic signed [GRAD_WIDTH-1:0]   gx,
   input  logic signed [GRAD_WIDTH-1:0]   gy,
   input  logic signed [GRAD_WIDTH-1:0]   gt,
   output logic signed [TENSOR_WIDTH-1:0] xx,
   output logic signed [TENSOR_WIDTH-1:0] yy,
   output logic signed [TENSOR_WIDTH-1:0] tt,
   output logic signed [TENSOR_WIDTH-1:0] xy,
   output logic signed [TENSOR_WIDTH-1:0] xt,
   output logic signed [TENSOR_WIDTH-1:0] yt,
   output logic                           tensor_valid
);

   // No handshake: en advances every register at once, one sample per enabled edge,
   // and nothing downstream can stall this block.
   localparam int PW = 2 * GRAD_WIDTH;
   localparam int NC = 6;
   localparam int FW = $clog2(WINDOW + 1);
   localparam logic [FW-1:0] FILL_MAX = FW'(WINDOW);

   logic signed [PW-1:0]           gx_e, gy_e, gt_e;
   logic signed [PW-1:0]           prod [NC];
   logic signed [TENSOR_WIDTH-1:0] s1_p [NC];
   logic                           s1_v;
   logic                           start_d;
   logic signed [TENSOR_WIDTH-1:0] hist [NC][WINDOW];
   logic signed [TENSOR_WIDTH-1:0] sum  [NC];
   logic [FW-1:0]                  fill;
   logic [FW-1:0]                  fill_nxt;

   // Operands widened first so each product is formed at full 2*GRAD_WIDTH precision.
   assign gx_e = {{GRAD_WIDTH{gx[GRAD_WIDTH-1]}}, gx};
   assign gy_e = {{GRAD_WIDTH{gy[GRAD_WIDTH-1]}}, gy};
   assign gt_e = {{GRAD_WIDTH{gt[GRAD_WIDTH-1]}}, gt};

   always_comb begin
      prod[0] = gx_e * gx_e;
      prod[1] = gy_e * gy_e;
      prod[2] = gt_e * gt_e;
      prod[3] = gx_e * gy_e;
      prod[4] = gx_e * gt_e;
      prod[5] = gy_e * gt_e;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NC; c++) s1_p[c] <= '0;
         s1_v    <= 1'b0;
         start_d <= 1'b0;
      end else if (en) begin
         for (int c = 0; c < NC; c++)
            s1_p[c] <= {{(TENSOR_WIDTH-PW){prod[c][PW-1]}}, prod[c]};
         s1_v    <= 1'b1;
         start_d <= line_start;
      end
   end

   always_comb begin
      fill_nxt = fill;
      if (start_d)
         fill_nxt = FW'(1);
      else if (fill != FILL_MAX)
         fill_nxt = fill + FW'(1);
   end

   // The running sum always equals the sum of the history entries, so dropping the
   // oldest entry on each update keeps it exact; clearing history on restart keeps
   // the partial sums of a new line free of the previous line's samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NC; c++) begin
            sum[c] <= '0;
            for (int w = 0; w < WINDOW; w++) hist[c][w] <= '0;
         end
         fill         <= '0;
         tensor_valid <= 1'b0;
      end else if (en && s1_v) begin
         for (int c = 0; c < NC; c++) begin
            hist[c][0] <= s1_p[c];
            if (start_d) begin
               sum[c] <= s1_p[c];
               for (int w = 1; w < WINDOW; w++) hist[c][w] <= '0;
            end else begin
               sum[c] <= sum[c] + s1_p[c] - hist[c][WINDOW-1];
               for (int w = 1; w < WINDOW; w++) hist[c][w] <= hist[c][w-1];
            end
         end
         fill         <= fill_nxt;
         tensor_valid <= (fill_nxt == FILL_MAX);
      end
   end

   assign xx = sum[0];
   assign yy = sum[1];
   assign tt = sum[2];
   assign xy = sum[3];
   assign xt = sum[4];
   assign yt = sum[5];

endmodule

// File: tb/tb_structure_tensor_gen.sv
// Bench for structure_tensor_gen: a line-queue model of the windowed sums checked every
// cycle, plus literal expectations from hand-computed directed vectors.
module tb_structure_tensor_gen;

   localparam int GW = 10;
   localparam int TW = 24;
   localparam int W  = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic line_start = 1'b0;
   logic signed [GW-1:0] gx = '0, gy = '0, gt = '0;
   logic signed [TW-1:0] xx, yy, tt, xy, xt, yt;
   logic tensor_valid;

   int checks = 0;
   int errors = 0;

   // Model state: samples of the current line (last W only) and the sample
   // accepted on the previous enabled edge, which reaches the outputs one edge later.
   int q_gx[$], q_gy[$], q_gt[$];
   bit pend_v = 0, pend_ls = 0;
   int pend_gx = 0, pend_gy = 0, pend_gt = 0;
   int exp_xx = 0, exp_yy = 0, exp_tt = 0, exp_xy = 0, exp_xt = 0, exp_yt = 0;
   bit exp_v = 0;

   always #5 clk = ~clk;

   structure_tensor_gen #(.GRAD_WIDTH(GW), .TENSOR_WIDTH(TW), .WINDOW(W)) dut (
      .clk(clk), .rst(rst), .en(en), .line_start(line_start),
      .gx(gx), .gy(gy), .gt(gt),
      .xx(xx), .yy(yy), .tt(tt), .xy(xy), .xt(xt), .yt(yt),
      .tensor_valid(tensor_valid)
   );

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      q_gx.delete(); q_gy.delete(); q_gt.delete();
      pend_v = 0;
      exp_xx = 0; exp_yy = 0; exp_tt = 0; exp_xy = 0; exp_xt = 0; exp_yt = 0;
      exp_v = 0;
   endtask

   task automatic model_edge(input bit ls, input int a, input int b, input int c);
      if (pend_v) begin
         if (pend_ls) begin
            q_gx.delete(); q_gy.delete(); q_gt.delete();
         end
         q_gx.push_back(pend_gx); q_gy.push_back(pend_gy); q_gt.push_back(pend_gt);
         if (q_gx.size() > W) begin
            void'(q_gx.pop_front()); void'(q_gy.pop_front()); void'(q_gt.pop_front());
         end
         exp_xx = 0; exp_yy = 0; exp_tt = 0; exp_xy = 0; exp_xt = 0; exp_yt = 0;
         foreach (q_gx[i]) begin
            exp_xx += q_gx[i] * q_gx[i];
            exp_yy += q_gy[i] * q_gy[i];
            exp_tt += q_gt[i] * q_gt[i];
            exp_xy += q_gx[i] * q_gy[i];
            exp_xt += q_gx[i] * q_gt[i];
            exp_yt += q_gy[i] * q_gt[i];
         end
         exp_v = (q_gx.size() == W);
      end
      pend_v = 1; pend_ls = ls; pend_gx = a; pend_gy = b; pend_gt = c;
   endtask

   // One clock: drive, take the edge, then let the model see the accepted sample.
   task automatic step(input bit e, input bit ls, input int a, input int b, input int c);
      en = e;
      if (e) begin
         line_start = ls;
         gx = GW'(a); gy = GW'(b); gt = GW'(c);
      end else begin
         line_start = 1'($urandom_range(0, 1));
         gx = GW'($urandom_range(0, 1023));
         gy = GW'($urandom_range(0, 1023));
         gt = GW'($urandom_range(0, 1023));
      end
      @(posedge clk);
      #1;
      if (e && !rst) model_edge(ls, a, b, c);
   endtask

   task automatic chk_all_lit(input string nm, input int v, input bit tv);
      chk({nm, "_xx"}, int'(xx), v); chk({nm, "_yy"}, int'(yy), v);
      chk({nm, "_tt"}, int'(tt), v); chk({nm, "_xy"}, int'(xy), v);
      chk({nm, "_xt"}, int'(xt), v); chk({nm, "_yt"}, int'(yt), v);
      chk({nm, "_valid"}, int'(tensor_valid), int'(tv));
   endtask

   task automatic ramp(input bit gated, input string nm);
      int got[$];
      int ref_v[4];
      ref_v = '{55, 90, 135, 190};
      step(1, 1, 1, 0, 0);
      for (int k = 2; k <= 9; k++) begin
         if (k == 9) step(1, 1, 0, 0, 0);
         else step(1, 0, k, 0, 0);
         if (tensor_valid) got.push_back(int'(xx));
         if (gated && k == 4) begin
            for (int g = 0; g < 3; g++) step(0, 0, 0, 0, 0);
         end
      end
      chk({nm, "_count"}, got.size(), 4);
      for (int i = 0; i < 4; i++)
         chk({nm, "_xx"}, (i < got.size()) ? got[i] : -1, ref_v[i]);
   endtask

   always @(negedge clk) begin
      chk("cyc_xx", int'(xx), exp_xx);
      chk("cyc_yy", int'(yy), exp_yy);
      chk("cyc_tt", int'(tt), exp_tt);
      chk("cyc_xy", int'(xy), exp_xy);
      chk("cyc_xt", int'(xt), exp_xt);
      chk("cyc_yt", int'(yt), exp_yt);
      chk("cyc_valid", int'(tensor_valid), int'(exp_v));
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_all_lit("reset", 0, 0);
      rst = 0;

      // Constant gradients 3, 4, -2
      for (int i = 1; i <= 8; i++) begin
         step(1, (i == 1), 3, 4, -2);
         if (i >= 2 && i <= 5) begin
            chk("const_partial_xx", int'(xx), 9 * (i - 1));
            chk("const_partial_valid", int'(tensor_valid), 0);
         end
         if (i >= 6) begin
            chk("const_xx", int'(xx), 45);  chk("const_yy", int'(yy), 80);
            chk("const_tt", int'(tt), 20);  chk("const_xy", int'(xy), 60);
            chk("const_xt", int'(xt), -30); chk("const_yt", int'(yt), -40);
            chk("const_valid", int'(tensor_valid), 1);
         end
      end

      // Extreme values
      for (int i = 1; i <= 5; i++) step(1, (i == 1), -512, -512, -512);
      step(1, 1, -512, 511, 0);
      chk_all_lit("extreme", 1310720, 1);
      for (int i = 2; i <= 5; i++) step(1, 0, -512, 511, 0);
      step(1, 1, 0, 0, 0);
      chk("extreme_xy", int'(xy), -1308160);
      chk("extreme_yy", int'(yy), 1305605);
      chk("extreme_valid", int'(tensor_valid), 1);

      // Line restart on the 7th sample
      for (int i = 1; i <= 13; i++) begin
         step(1, (i == 1 || i == 7), 3, 4, -2);
         if (i == 8) begin
            chk("restart_xx", int'(xx), 9);
            chk("restart_valid", int'(tensor_valid), 0);
         end
         if (i == 11) chk("restart_prevalid", int'(tensor_valid), 0);
         if (i == 12) begin
            chk("restart_refill_xx", int'(xx), 45);
            chk("restart_refill_valid", int'(tensor_valid), 1);
         end
      end

      // Sliding window, ungated and with an en=0 gap mid-window
      ramp(0, "ramp");
      ramp(1, "ramp_gated");

      // Asynchronous reset mid-stream
      for (int i = 1; i <= 7; i++) step(1, (i == 1), 3, 4, -2);
      #2;
      rst = 1;
      model_reset();
      #1;
      chk_all_lit("async_rst", 0, 0);
      @(posedge clk);
      #1;
      rst = 0;
      for (int i = 1; i <= 7; i++) begin
         step(1, 0, 3, 4, -2);
         if (i == 5) chk("post_rst_prevalid", int'(tensor_valid), 0);
         if (i == 6) begin
            chk("post_rst_valid", int'(tensor_valid), 1);
            chk("post_rst_xx", int'(xx), 45);
         end
      end

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
